// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: shadows the write-back info of
// the two instructions ahead of ID, registers the EX operand selects, and owns load-use and mult/div stalls.
module hazard_forward_ctrl #(
  parameter int REG_AW     = 5,
  parameter int MD_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ext_stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_regwrite,
  input  logic [REG_AW-1:0] id_wreg,
  input  logic [1:0]        id_memtoreg,
  input  logic              id_md_start,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              bubble_idex,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              md_busy
);

  localparam int CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [REG_AW-1:0] wreg;
    logic [1:0]        memtoreg;
  } sh_t;

  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

  sh_t              sh1, sh2, id_entry;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       fwd_a, fwd_b;
  logic             lu, issue, in_wait;

  // r0 is hard-wired zero, so a write to it never produces a value worth forwarding.
  function automatic logic writes(input sh_t e, input logic [REG_AW-1:0] r);
    return e.valid & e.regwrite & (e.wreg == r) & (r != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input sh_t s1, input sh_t s2,
                                         input logic [REG_AW-1:0] r, input logic used);
    logic [1:0] sel;
    sel = 2'b00;
    if (used) begin
      if (writes(s1, r))      sel = 2'b01;
      else if (writes(s2, r)) sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    id_entry          = '0;
    id_entry.valid    = 1'b1;
    id_entry.regwrite = id_regwrite;
    id_entry.wreg     = id_wreg;
    id_entry.memtoreg = id_memtoreg;
  end

  assign in_wait = (state == MD_WAIT);
  assign fwd_a   = fwd_sel(sh1, sh2, id_rs, id_use_rs);
  assign fwd_b   = fwd_sel(sh1, sh2, id_rt, id_use_rt);

  // A load one ahead has no data yet; flush wins because the dependent instruction dies anyway.
  assign lu = !in_wait && !flush && (sh1.memtoreg == 2'b01) &&
              ((id_use_rs && writes(sh1, id_rs)) || (id_use_rt && writes(sh1, id_rt)));

  assign issue       = !ext_stall && !flush && !lu && !in_wait;
  assign stall_pc    = ext_stall | lu | in_wait;
  assign stall_ifid  = stall_pc;
  assign bubble_idex = !ext_stall & (lu | flush | in_wait);
  assign md_busy     = in_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh1      <= '0;
      sh2      <= '0;
      ForwardA <= 2'b00;
      ForwardB <= 2'b00;
      state    <= RUN;
      cnt      <= '0;
    end else if (!ext_stall) begin
      sh2      <= sh1;
      sh1      <= issue ? id_entry : '0;
      ForwardA <= issue ? fwd_a : 2'b00;
      ForwardB <= issue ? fwd_b : 2'b00;
      case (state)
        RUN: begin
          if (issue && id_md_start) begin
            state <= MD_WAIT;
            cnt   <= CNT_W'(MD_LATENCY - 1);
          end
        end
        MD_WAIT: begin
          // The held ID instruction may issue in the very first RUN cycle after this.
          if (cnt == '0) state <= RUN;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: forwarding, load-use, mult/div wait, flush and reset cases
// with hand-computed expectations checked by immediate assertions.
module tb_hazard_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ext_stall, flush;
  logic [4:0] id_rs, id_rt, id_wreg;
  logic       id_use_rs, id_use_rt, id_regwrite, id_md_start;
  logic [1:0] id_memtoreg;
  logic       stall_pc, stall_ifid, bubble_idex, md_busy;
  logic [1:0] ForwardA, ForwardB;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_forward_ctrl #(.REG_AW(5), .MD_LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_regwrite(id_regwrite), .id_wreg(id_wreg), .id_memtoreg(id_memtoreg),
    .id_md_start(id_md_start), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .bubble_idex(bubble_idex), .ForwardA(ForwardA), .ForwardB(ForwardB), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic rw, input logic [4:0] wreg,
                       input logic [1:0] mtr, input logic md);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_regwrite = rw; id_wreg = wreg; id_memtoreg = mtr; id_md_start = md;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stalls(input string tag, input logic st, input logic bub);
    check({tag, "_stall_pc"}, {7'b0, stall_pc}, {7'b0, st});
    check({tag, "_stall_ifid"}, {7'b0, stall_ifid}, {7'b0, st});
    check({tag, "_bubble"}, {7'b0, bubble_idex}, {7'b0, bub});
  endtask

  task automatic check_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
    check({tag, "_fwdA"}, {6'b0, ForwardA}, {6'b0, a});
    check({tag, "_fwdB"}, {6'b0, ForwardB}, {6'b0, b});
  endtask

  initial begin
    rst_n = 1'b0; ext_stall = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
    #12;
    check_fwd("reset", 2'b00, 2'b00);
    check_stalls("reset", 1'b0, 1'b0);
    check("reset_md_busy", {7'b0, md_busy}, 8'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // ALU r3 then reader rs=r3 -> forward from EX.
    drive(0, 0, 0, 0, 1, 3, 2'b00, 0); tick();
    drive(3, 9, 1, 1, 0, 0, 2'b00, 0);
    check_stalls("alu1", 1'b0, 1'b0);
    tick();
    check_fwd("alu1", 2'b01, 2'b00);

    // Writer r3, unrelated, reader rt=r3 -> forward from MEM.
    drive(0, 0, 0, 0, 1, 3, 2'b00, 0); tick();
    drive(0, 0, 0, 0, 1, 7, 2'b00, 0); tick();
    drive(1, 3, 1, 1, 0, 0, 2'b00, 0); tick();
    check_fwd("mem2", 2'b00, 2'b10);

    // Two writers of r3: the newest wins.
    drive(0, 0, 0, 0, 1, 3, 2'b00, 0); tick();
    drive(0, 0, 0, 0, 1, 3, 2'b00, 0); tick();
    drive(3, 3, 1, 1, 0, 0, 2'b00, 0); tick();
    check_fwd("newest", 2'b01, 2'b01);

    // Load r5 then reader rs=r5: one-cycle stall, then MEM forward.
    drive(0, 0, 0, 0, 1, 5, 2'b01, 0); tick();
    drive(5, 0, 1, 0, 0, 0, 2'b00, 0);
    check_stalls("lu_hit", 1'b1, 1'b1);
    tick();
    check_fwd("lu_bubble", 2'b00, 2'b00);
    check_stalls("lu_release", 1'b0, 1'b0);
    tick();
    check_fwd("lu_issue", 2'b10, 2'b00);

    // r0 writes never forward; unused operand never forwards.
    drive(0, 0, 0, 0, 1, 0, 2'b01, 0); tick();
    drive(0, 0, 1, 1, 0, 0, 2'b00, 0);
    check_stalls("r0_load", 1'b0, 1'b0);
    tick();
    check_fwd("r0", 2'b00, 2'b00);
    drive(0, 0, 0, 0, 1, 6, 2'b00, 0); tick();
    drive(6, 6, 0, 1, 0, 0, 2'b00, 0); tick();
    check_fwd("unused_rs", 2'b00, 2'b01);

    // Mult/div: four busy cycles with stalls, then the held instruction issues.
    drive(0, 0, 0, 0, 1, 8, 2'b00, 1);
    check_stalls("md_issue", 1'b0, 1'b0);
    tick();
    drive(8, 0, 1, 0, 0, 0, 2'b00, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("md_busy_%0d", i), {7'b0, md_busy}, 8'd1);
      check_stalls($sformatf("md_wait_%0d", i), 1'b1, 1'b1);
      tick();
    end
    check("md_done", {7'b0, md_busy}, 8'd0);
    check_stalls("md_done", 1'b0, 1'b0);
    tick();
    check_fwd("md_held_issue", 2'b00, 2'b00);

    // ext_stall in the middle of the wait stretches it by one cycle.
    drive(0, 0, 0, 0, 1, 8, 2'b00, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
    check("mdx_busy_0", {7'b0, md_busy}, 8'd1);
    tick();
    ext_stall = 1'b1; #1;
    check("mdx_frozen_busy", {7'b0, md_busy}, 8'd1);
    check_stalls("mdx_ext", 1'b1, 1'b0);
    tick();
    ext_stall = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mdx_busy_%0d", i + 1), {7'b0, md_busy}, 8'd1);
      tick();
    end
    check("mdx_done", {7'b0, md_busy}, 8'd0);
    tick();

    // Flush in the load-use cycle: no stall, bubble, and the killed slot leaves sh1 empty.
    drive(0, 0, 0, 0, 1, 5, 2'b01, 0); tick();
    drive(5, 0, 1, 0, 0, 0, 2'b00, 0);
    flush = 1'b1; #1;
    check_stalls("flush_lu", 1'b0, 1'b1);
    tick();
    flush = 1'b0; #1;
    check_fwd("flush_bubble", 2'b00, 2'b00);
    check_stalls("flush_after", 1'b0, 1'b0);
    tick();
    check_fwd("flush_mem", 2'b10, 2'b00);

    // Reset in the middle of a mult/div wait returns everything to idle at once.
    drive(0, 0, 0, 0, 1, 9, 2'b00, 1); tick();
    drive(9, 9, 1, 1, 0, 0, 2'b00, 0); tick();
    check("rstmd_busy_pre", {7'b0, md_busy}, 8'd1);
    rst_n = 1'b0; #1;
    check("rstmd_busy", {7'b0, md_busy}, 8'd0);
    check_stalls("rstmd", 1'b0, 1'b0);
    check_fwd("rstmd", 2'b00, 2'b00);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
